pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Top-level game sequencer for Pong. Owns the two paddle instances (left and right) and the ball.
- Resets and re-centres the paddles, gates player buttons into them, enables and releases the ball, counts serve and point pauses in frames, keeps score and declares a winner.
- Sits between the button/VGA frame-tick logic and the paddle and ball datapaths.

Parameters:
- SERVE_FRAMES, 60: frame ticks to wait in SERVE before the ball is released.
- POINT_FRAMES, 30: frame ticks to pause in POINT after a miss.
- WIN_SCORE, 7: score that ends the game; must be < 2**SCORE_WIDTH.
- SCORE_WIDTH, 4: width of each score counter.
- CNT_WIDTH, 8: width of the frame countdown; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  start/restart request, level-sampled each cycle.
- btn_l  in  2  left player buttons (01 up, 10 down).
- btn_r  in  2  right player buttons.
- miss_l  in  1  ball passed left paddle (one-cycle pulse from ball block).
- miss_r  in  1  ball passed right paddle.
- paddle_rst  out  1  active-high reset to both paddles (re-centres them at 240).
- btn_l_out  out  2  gated buttons to left paddle.
- btn_r_out  out  2  gated buttons to right paddle.
- ball_rst  out  1  active-high ball reset (ball to centre).
- ball_en  out  1  ball motion enable.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- score_l  out  SCORE_WIDTH  left score.
- score_r  out  SCORE_WIDTH  right score.
- winner  out  2  00 none, 01 left, 10 right.
- state  out  3  current state encoding.

Behaviour:
- Reset (rst==0 at a clk edge, any state, mid-game included), effective next edge:
  - state=IDLE; score_l=score_r=0; winner=00; serve_dir=0; counter=0.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4; 5–7 unreachable, recover to IDLE next cycle.
- Outputs paddle_rst, ball_rst, ball_en and the button gates are combinational decodes of the registered state; no added latency:
  - IDLE: paddle_rst=1, ball_rst=1, ball_en=0, btn outs=00.
  - SERVE: paddle_rst=0, ball_rst=1, ball_en=0, btn_x_out=btn_x.
  - PLAY: paddle_rst=0, ball_rst=0, ball_en=1, btn_x_out=btn_x.
  - POINT: paddle_rst=1, ball_rst=0, ball_en=0, btn outs=00.
  - GAME_OVER: paddle_rst=1, ball_rst=1, ball_en=0, btn outs=00.
- Transitions:
  - IDLE: start=1 -> SERVE; clear scores and winner; counter=SERVE_FRAMES.
  - SERVE: frame_tick with counter>0 decrements counter. When counter==0 -> PLAY next edge. SERVE_FRAMES=0 gives exactly one cycle in SERVE.
  - PLAY:
    - miss_l=1 only -> score_r+1, serve_dir=0 (serve to loser), counter=POINT_FRAMES, -> POINT.
    - miss_r=1 only -> score_l+1, serve_dir=1, -> POINT.
    - Both miss_l and miss_r in the same cycle -> no score change, serve_dir unchanged, -> POINT.
  - POINT: counter decrements on frame_tick. When counter==0:
    - if score_l==WIN_SCORE -> GAME_OVER, winner=01.
    - else if score_r==WIN_SCORE -> GAME_OVER, winner=10.
    - else -> SERVE, counter=SERVE_FRAMES.
  - GAME_OVER: start=1 -> SERVE; scores=0; winner=00; serve_dir kept; counter=SERVE_FRAMES.
- Ignored inputs:
  - start is ignored in SERVE, PLAY and POINT.
  - miss_l/miss_r are ignored outside PLAY.
  - frame_tick is ignored in IDLE, PLAY and GAME_OVER.
- A frame_tick in the same cycle as a transition into SERVE/POINT does not decrement; the counter loads its reload value.
- Scores only increment in PLAY and never exceed WIN_SCORE; no wrap.
- rst=0 has priority over start, miss and frame_tick in the same cycle.

Test Plan:
Bench overrides: SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2.
- Reset and start:
  - rst=0 for 2 cycles -> state=0, paddle_rst=1, ball_rst=1, scores 0, winner=00.
  - rst=1, start pulse -> state=1 next edge, paddle_rst=0, btn_l_out follows btn_l=01.
  - 3 frame_ticks -> state=2, ball_en=1 one cycle after the third tick.
- Scoring a point:
  - In PLAY, miss_l pulse -> score_r=1, serve_dir=0, state=3, paddle_rst=1, btn_l_out=00 while btn_l=01.
  - 2 ticks -> state=1, counter reloaded to 3.
- Simultaneous miss:
  - In PLAY, miss_l=miss_r=1 same cycle -> state=3, scores unchanged, serve_dir unchanged.
- Reaching the win score:
  - Drive miss_r twice across two rallies -> score_l=2.
  - After 2 POINT ticks -> state=4, winner=01, ball_rst=1.
  - start -> state=1, scores 0, winner=00.
- Ignored inputs:
  - miss_l in SERVE and start in PLAY -> no state or score change.
  - frame_tick in the cycle of entering SERVE -> still exactly 3 further ticks before PLAY.
- Mid-game reset:
  - rst=0 in POINT with counter=1 and score_r=1 -> next edge state=0, scores 0, counter 0, paddle_rst=1.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer driving paddles, ball enable, serve/point pauses, score and winner.
module pong_game_ctrl #(
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_WIDTH  = 4,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_tick,
   input  logic                   start,
   input  logic [1:0]             btn_l,
   input  logic [1:0]             btn_r,
   input  logic                   miss_l,
   input  logic                   miss_r,
   output logic                   paddle_rst,
   output logic [1:0]             btn_l_out,
   output logic [1:0]             btn_r_out,
   output logic                   ball_rst,
   output logic                   ball_en,
   output logic                   serve_dir,
   output logic [SCORE_WIDTH-1:0] score_l,
   output logic [SCORE_WIDTH-1:0] score_r,
   output logic [1:0]             winner,
   output logic [2:0]             state
);
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, GAME_OVER = 3'd4} state_t;
   localparam logic [CNT_WIDTH-1:0]   SERVE_LD = CNT_WIDTH'(SERVE_FRAMES);
   localparam logic [CNT_WIDTH-1:0]   POINT_LD = CNT_WIDTH'(POINT_FRAMES);
   localparam logic [SCORE_WIDTH-1:0] WIN      = SCORE_WIDTH'(WIN_SCORE);
   localparam logic [SCORE_WIDTH-1:0] ONE_PT   = SCORE_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]   ONE_CNT  = CNT_WIDTH'(1);
   state_t st;
   logic [CNT_WIDTH-1:0] cnt;
   logic gate;
   always_ff @(posedge clk) begin
      if (!rst) begin
         st        <= IDLE;
         score_l   <= '0;
         score_r   <= '0;
         winner    <= 2'b00;
         serve_dir <= 1'b0;
         cnt       <= '0;
      end else begin
         case (st)
            IDLE, GAME_OVER: if (start) begin
               st      <= SERVE;
               score_l <= '0;
               score_r <= '0;
               winner  <= 2'b00;
               cnt     <= SERVE_LD;
            end
            SERVE: begin
               if (cnt == '0) st <= PLAY;
               else if (frame_tick) cnt <= cnt - ONE_CNT;
            end
            PLAY: if (miss_l || miss_r) begin
               st  <= POINT;
               cnt <= POINT_LD;
               // a double miss is a replay: nobody scores, serve side stays
               if (miss_l && !miss_r) begin
                  score_r   <= (score_r < WIN) ? score_r + ONE_PT : score_r;
                  serve_dir <= 1'b0;
               end else if (miss_r && !miss_l) begin
                  score_l   <= (score_l < WIN) ? score_l + ONE_PT : score_l;
                  serve_dir <= 1'b1;
               end
            end
            POINT: begin
               if (cnt == '0) begin
                  if (score_l == WIN) begin
                     st     <= GAME_OVER;
                     winner <= 2'b01;
                  end else if (score_r == WIN) begin
                     st     <= GAME_OVER;
                     winner <= 2'b10;
                  end else begin
                     st  <= SERVE;
                     cnt <= SERVE_LD;
                  end
               end else if (frame_tick) cnt <= cnt - ONE_CNT;
            end
            default: st <= IDLE;
         endcase
      end
   end
   always_comb begin
      gate       = (st == SERVE) || (st == PLAY);
      paddle_rst = (st == IDLE) || (st == POINT) || (st == GAME_OVER);
      ball_rst   = (st == IDLE) || (st == SERVE) || (st == GAME_OVER);
      ball_en    = (st == PLAY);
      btn_l_out  = gate ? btn_l : 2'b00;
      btn_r_out  = gate ? btn_r : 2'b00;
      state      = st;
   end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: randomized and directed stimulus, expected outputs queued from a reference model.
module tb_pong_game_ctrl;
   localparam int SF = 3, PF = 2, WS = 2;
   logic clk = 0, rst = 0, frame_tick = 0, start = 0, miss_l = 0, miss_r = 0;
   logic [1:0] btn_l = 0, btn_r = 0, btn_l_out, btn_r_out, winner;
   logic paddle_rst, ball_rst, ball_en, serve_dir;
   logic [3:0] score_l, score_r;
   logic [2:0] state;
   int checks = 0, errors = 0;
   pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS), .SCORE_WIDTH(4), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .btn_l(btn_l), .btn_r(btn_r),
      .miss_l(miss_l), .miss_r(miss_r), .paddle_rst(paddle_rst), .btn_l_out(btn_l_out), .btn_r_out(btn_r_out),
      .ball_rst(ball_rst), .ball_en(ball_en), .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
      .winner(winner), .state(state));
   always #5 clk = ~clk;
   typedef struct {int st, sl, sr, win, sd, pr, br, be, bl, brt;} exp_t;
   exp_t q[$];
   // per-phase output table, indexed by phase number IDLE..GAME_OVER
   int pr_tab[5] = '{1, 0, 0, 1, 1};
   int br_tab[5] = '{1, 1, 0, 0, 1};
   int be_tab[5] = '{0, 0, 1, 0, 0};
   int gt_tab[5] = '{0, 1, 1, 0, 0};
   int m_st = 0, m_sl = 0, m_sr = 0, m_win = 0, m_sd = 0, m_wait = 0;
   task automatic new_game();
      m_st = 1; m_sl = 0; m_sr = 0; m_win = 0; m_wait = SF;
   endtask
   task automatic model();
      if (!rst) begin
         m_st = 0; m_sl = 0; m_sr = 0; m_win = 0; m_sd = 0; m_wait = 0;
      end else if ((m_st == 0 || m_st == 4) && start) new_game();
      else if (m_st == 1) begin
         if (m_wait == 0) m_st = 2;
         else if (frame_tick) m_wait--;
      end else if (m_st == 2 && (miss_l || miss_r)) begin
         if (!(miss_l && miss_r)) begin
            m_sd = miss_r ? 1 : 0;
            if (miss_l) m_sr = (m_sr + 1 > WS) ? WS : m_sr + 1;
            else m_sl = (m_sl + 1 > WS) ? WS : m_sl + 1;
         end
         m_st = 3; m_wait = PF;
      end else if (m_st == 3) begin
         if (m_wait > 0) begin
            if (frame_tick) m_wait--;
         end else if (m_sl == WS || m_sr == WS) begin
            m_st = 4; m_win = (m_sl == WS) ? 1 : 2;
         end else begin
            m_st = 1; m_wait = SF;
         end
      end
   endtask
   task automatic cyc(input logic r, s, ft, ml, mr, input logic [1:0] bl, brr);
      exp_t e;
      @(negedge clk);
      rst = r; start = s; frame_tick = ft; miss_l = ml; miss_r = mr; btn_l = bl; btn_r = brr;
      model();
      e.st = m_st; e.sl = m_sl; e.sr = m_sr; e.win = m_win; e.sd = m_sd;
      e.pr = pr_tab[m_st]; e.br = br_tab[m_st]; e.be = be_tab[m_st];
      e.bl = gt_tab[m_st] ? int'(bl) : 0; e.brt = gt_tab[m_st] ? int'(brr) : 0;
      q.push_back(e);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 2'b01, 2'b10);
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin cyc(1, 0, 1, 0, 0, 2'b01, 2'b10); idle(1); end
   endtask
   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("state", int'(state), e.st);
         chk("score_l", int'(score_l), e.sl);
         chk("score_r", int'(score_r), e.sr);
         chk("winner", int'(winner), e.win);
         chk("serve_dir", int'(serve_dir), e.sd);
         chk("paddle_rst", int'(paddle_rst), e.pr);
         chk("ball_rst", int'(ball_rst), e.br);
         chk("ball_en", int'(ball_en), e.be);
         chk("btn_l_out", int'(btn_l_out), e.bl);
         chk("btn_r_out", int'(btn_r_out), e.brt);
      end
   end
   initial begin
      cyc(0, 0, 0, 0, 0, 2'b01, 2'b10);
      cyc(0, 1, 1, 1, 1, 2'b01, 2'b10);
      cyc(1, 1, 0, 0, 0, 2'b01, 2'b10);
      cyc(1, 0, 0, 1, 0, 2'b01, 2'b10);
      ticks(3); idle(2);
      cyc(1, 1, 0, 0, 0, 2'b11, 2'b10);
      cyc(1, 0, 0, 1, 0, 2'b01, 2'b10);
      ticks(2); idle(2);
      ticks(3); idle(2);
      cyc(1, 0, 0, 1, 1, 2'b01, 2'b10);
      ticks(2); idle(1); ticks(3); idle(2);
      cyc(1, 0, 0, 0, 1, 2'b01, 2'b10);
      ticks(2); idle(1); ticks(3); idle(2);
      cyc(1, 0, 0, 0, 1, 2'b01, 2'b10);
      ticks(2); idle(3);
      cyc(1, 1, 1, 0, 0, 2'b01, 2'b10);
      ticks(3); idle(2);
      cyc(1, 0, 0, 1, 0, 2'b01, 2'b10);
      ticks(1);
      cyc(0, 1, 1, 0, 0, 2'b01, 2'b10);
      idle(2);
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom_range(2) == 0,
             $urandom_range(9) == 0, $urandom_range(9) == 0, 2'($urandom), 2'($urandom));
      idle(3);
      repeat (2) @(posedge clk);
      #2;
      if (q.size() != 0) chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
